// File: rtl/bg_parallax_starfield_if.sv
// Signal bundle between the video timing/mux side and the parallax starfield generator.
// The master drives pixel coordinates, controls and vsync; the slave returns the tick and grey colour.
interface bg_parallax_starfield_if #(
    parameter int NUM_LAYERS = 3
);
    logic                      bg_en;
    logic                      pause;
    logic                      video_active;
    logic [10:0]               pix_x;
    logic [10:0]               pix_y;
    logic                      vsync;
    logic [8*NUM_LAYERS-1:0]   layer_speed;
    logic                      frame_tick;
    logic [1:0]                R;
    logic [1:0]                G;
    logic [1:0]                B;

    modport master (
        output bg_en, pause, video_active, pix_x, pix_y, vsync, layer_speed,
        input  frame_tick, R, G, B
    );

    modport slave (
        input  bg_en, pause, video_active, pix_x, pix_y, vsync, layer_speed,
        output frame_tick, R, G, B
    );
endinterface

// File: rtl/bg_parallax_starfield.sv
// Procedural multi-layer scrolling starfield: per-cell hashed stars, per-layer runtime scroll speed,
// frame timing from a synchronised vsync edge, 2-stage pixel pipeline producing grey 2-bit colour.
module bg_parallax_starfield #(
    parameter int          NUM_LAYERS = 3,
    parameter int          H_RES      = 1024,
    parameter int          V_RES      = 768,
    parameter int          CELL_LOG2  = 4,
    parameter logic [7:0]  DENSITY    = 8'd40,
    parameter int          TWINKLE    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bg_parallax_starfield_if.slave bus
);
    localparam logic [11:0] H_RES_W = 12'(H_RES);
    localparam logic [10:0] V_RES_W = 11'(V_RES);

    // vsync synchroniser and rising-edge detect
    logic       vs_meta_q, vs_meta_d;
    logic       vs_sync_q, vs_sync_d;
    logic       vs_prev_q, vs_prev_d;
    logic [2:0] vs_vld_q, vs_vld_d;
    logic       frame_tick_q, frame_tick_d;
    logic [2:0] frame_cnt_q, frame_cnt_d;

    // vs_vld marks which sync stages hold a real post-reset sample, so a vsync
    // already high at reset release cannot masquerade as a rising edge.
    always_comb begin
        vs_meta_d    = bus.vsync;
        vs_sync_d    = vs_meta_q;
        vs_prev_d    = vs_sync_q;
        vs_vld_d     = {vs_vld_q[1:0], 1'b1};
        frame_tick_d = vs_sync_q & ~vs_prev_q & vs_vld_q[2];
        frame_cnt_d  = frame_cnt_q;
        if (frame_tick_q && bus.bg_en) begin
            frame_cnt_d = frame_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_meta_q    <= 1'b0;
            vs_sync_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            vs_vld_q     <= 3'b000;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 3'd0;
        end else begin
            vs_meta_q    <= vs_meta_d;
            vs_sync_q    <= vs_sync_d;
            vs_prev_q    <= vs_prev_d;
            vs_vld_q     <= vs_vld_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign bus.frame_tick = frame_tick_q;

    // Shared stage-1 registers: cell row, in-cell row and the visibility qualifier
    logic [7:0]           cy_q, cy_d;
    logic [CELL_LOG2-1:0] iy_q, iy_d;
    logic                 qual_q, qual_d;

    always_comb begin
        cy_d   = 8'(bus.pix_y >> CELL_LOG2);
        iy_d   = bus.pix_y[CELL_LOG2-1:0];
        qual_d = bus.video_active & bus.bg_en & (bus.pix_y < V_RES_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cy_q   <= 8'd0;
            iy_q   <= '0;
            qual_q <= 1'b0;
        end else begin
            cy_q   <= cy_d;
            iy_q   <= iy_d;
            qual_q <= qual_d;
        end
    end

    logic [NUM_LAYERS-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            localparam logic [7:0] SEED = 8'(8'h5A + 8'h27 * gi);

            logic [10:0] off_q, off_d;
            logic [11:0] off_sum;
            logic [10:0] xs_q, xs_d;
            logic [11:0] x_sum;
            logic [7:0]  cx;
            logic [7:0]  h;
            logic [7:0]  h2;
            logic        twinkle_off;

            assign off_sum = {1'b0, off_q} + {4'b0000, bus.layer_speed[8*gi +: 8]};
            assign x_sum   = {1'b0, bus.pix_x} + {1'b0, off_q};

            always_comb begin
                off_d = off_q;
                if (frame_tick_q && bus.bg_en && !bus.pause) begin
                    off_d = (off_sum >= H_RES_W) ? 11'(off_sum - H_RES_W) : off_sum[10:0];
                end
                xs_d = (x_sum >= H_RES_W) ? 11'(x_sum - H_RES_W) : x_sum[10:0];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    off_q <= 11'd0;
                    xs_q  <= 11'd0;
                end else begin
                    off_q <= off_d;
                    xs_q  <= xs_d;
                end
            end

            // Stage 2: hash the cell, locate its single star pixel, apply twinkle
            assign cx          = 8'(xs_q >> CELL_LOG2);
            assign h           = (cx * 8'h9D) ^ (cy_q * 8'h3B) ^ SEED;
            assign h2          = {h[3:0], h[7:4]} ^ 8'hA5;
            assign twinkle_off = (TWINKLE != 0) && (h[2:0] == frame_cnt_q);
            assign hit[gi]     = (h < DENSITY)
                               && (xs_q[CELL_LOG2-1:0] == h2[CELL_LOG2-1:0])
                               && (iy_q == h2[4 +: CELL_LOG2])
                               && !twinkle_off;
        end
    endgenerate

    logic [1:0] color_q, color_d;

    // Ascending scan so the nearest (highest-index) layer overrides farther ones
    always_comb begin
        color_d = 2'd0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (hit[k]) begin
                color_d = (k >= 2) ? 2'd3 : 2'(k + 1);
            end
        end
        if (!qual_q) begin
            color_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q <= 2'd0;
        end else begin
            color_q <= color_d;
        end
    end

    assign bus.R = color_q;
    assign bus.G = color_q;
    assign bus.B = color_q;
endmodule

// File: tb/tb_bg_parallax_starfield.sv
// Scoreboard bench for bg_parallax_starfield: a hash/offset/frame-count model predicts each pixel,
// expectations are queued at drive time and compared when the 2-cycle pipeline delivers them.
module tb_bg_parallax_starfield;
    localparam int         NL  = 3;
    localparam int         HR  = 1024;
    localparam int         VR  = 768;
    localparam int         CL  = 4;
    localparam logic [7:0] DEN = 8'd255;
    localparam int         TW  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bg_parallax_starfield_if #(.NUM_LAYERS(NL)) bus();

    bg_parallax_starfield #(
        .NUM_LAYERS(NL), .H_RES(HR), .V_RES(VR), .CELL_LOG2(CL),
        .DENSITY(DEN), .TWINKLE(TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;
    int off_m[NL];
    int spd_m[NL];
    int fcnt_m;

    typedef struct {
        logic [1:0] rgb;
        bit         chk;
        int         x;
        int         y;
    } exp_t;
    exp_t sbq[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.frame_tick === 1'b1) tick_cnt++;
    end

    function automatic logic [1:0] model_px(input int x, input int y, input bit va,
                                            input bit en, input bit ign_vres);
        int lvl = 0;
        int xs, cx, cy, h, h2, msk;
        msk = (1 << CL) - 1;
        if (!va || !en) return 2'd0;
        if (!ign_vres && y >= VR) return 2'd0;
        for (int k = 0; k < NL; k++) begin
            xs = x + off_m[k];
            if (xs >= HR) xs -= HR;
            cx = (xs >> CL) & 255;
            cy = (y >> CL) & 255;
            h  = ((cx * 157) & 255) ^ ((cy * 59) & 255) ^ ((90 + 39 * k) & 255);
            h2 = (((h & 15) << 4) | (h >> 4)) ^ 165;
            if (h < int'(DEN) && (xs & msk) == (h2 & msk) && (y & msk) == ((h2 >> 4) & msk)
                && !(TW != 0 && (h & 7) == fcnt_m))
                lvl = (k + 1 > 3) ? 3 : k + 1;
        end
        return 2'(lvl);
    endfunction

    task automatic set_speeds();
        for (int k = 0; k < NL; k++) bus.layer_speed[8*k +: 8] = spd_m[k][7:0];
    endtask

    task automatic model_tick();
        for (int k = 0; k < NL; k++) begin
            if (bus.bg_en && !bus.pause) begin
                off_m[k] = off_m[k] + spd_m[k];
                if (off_m[k] >= HR) off_m[k] -= HR;
            end
        end
        if (bus.bg_en) fcnt_m = (fcnt_m + 1) % 8;
    endtask

    // Called at posedge+1: drive one pixel, queue its expectation, advance a clock, retire the oldest
    task automatic step_px(input int x, input int y, input bit va, input bit chk);
        exp_t e;
        bus.pix_x        = 11'(x);
        bus.pix_y        = 11'(y);
        bus.video_active = va;
        e.rgb = model_px(x, y, va, bus.bg_en, 1'b0);
        e.chk = chk;
        e.x   = x;
        e.y   = y;
        sbq.push_back(e);
        @(posedge clk); #1;
        if (sbq.size() >= 2) begin
            e = sbq.pop_front();
            if (e.chk)
                check_val($sformatf("pix x=%0d y=%0d", e.x, e.y),
                          {26'd0, bus.R, bus.G, bus.B}, {26'd0, e.rgb, e.rgb, e.rgb});
        end
    endtask

    task automatic flush();
        step_px(0, 0, 1'b0, 1'b0);
        step_px(0, 0, 1'b0, 1'b0);
        sbq.delete();
    endtask

    task automatic sweep(input string name, input int x0, input int y0, input int w, input int hgt);
        for (int y = y0; y < y0 + hgt; y++)
            for (int x = x0; x < x0 + w; x++)
                step_px(x, y, 1'b1, 1'b1);
        flush();
        $display("sweep %s x0=%0d y0=%0d %0dx%0d off=%0d/%0d/%0d fcnt=%0d", name, x0, y0, w, hgt,
                 off_m[0], off_m[1], off_m[2], fcnt_m);
    endtask

    task automatic do_frame();
        bit seen = 1'b0;
        bus.vsync = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.vsync = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.frame_tick === 1'b1) seen = 1'b1;
        end
        check_val("tick_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        check_val("tick_width", 32'(bus.frame_tick), 32'd0);
        model_tick();
        $display("frame en=%0d pause=%0d off=%0d/%0d/%0d fcnt=%0d", bus.bg_en, bus.pause,
                 off_m[0], off_m[1], off_m[2], fcnt_m);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  xa, xb;
        bit  fa, fb;
        logic [1:0] ea;

        bus.bg_en        = 1'b1;
        bus.pause        = 1'b0;
        bus.video_active = 1'b1;
        bus.pix_x        = 11'd40;
        bus.pix_y        = 11'd40;
        bus.vsync        = 1'b0;
        bus.layer_speed  = '0;
        off_m  = '{default: 0};
        spd_m  = '{default: 0};
        fcnt_m = 0;
        set_speeds();

        // Reset held with vsync toggling and pixels moving
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            bus.vsync = ~bus.vsync;
            bus.pix_x = 11'(i * 7);
            bus.pix_y = 11'(i * 3);
            check_val("rst_rgb", {26'd0, bus.R, bus.G, bus.B}, 32'd0);
            check_val("rst_tick", 32'(bus.frame_tick), 32'd0);
        end
        bus.vsync = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        check_val("rel_no_tick", 32'(tick_cnt), 32'd0);
        $display("reset released with vsync high ticks=%0d", tick_cnt);

        // Tick latency, width, and single tick for a held vsync
        bus.vsync = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tick_cnt  = 0;
        bus.vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("tick_early", 32'(bus.frame_tick), 32'd0);
        @(posedge clk); #1;
        check_val("tick_lat", 32'(bus.frame_tick), 32'd1);
        model_tick();
        repeat (100) @(posedge clk);
        #1;
        check_val("tick_single", 32'(tick_cnt), 32'd1);
        $display("tick test ticks=%0d", tick_cnt);

        sweep("base", 0, 0, 64, 64);

        // Offset wrap: layer 0 at 200 px/frame
        spd_m[0] = 200; spd_m[1] = 13; spd_m[2] = 77;
        set_speeds();
        for (int f = 0; f < 6; f++) begin
            do_frame();
            sweep("wrap", 960, 32, 64, 16);
        end

        // Pause: offsets hold, frame counter still advances
        bus.pause = 1'b1;
        for (int f = 0; f < 4; f++) do_frame();
        bus.pause = 1'b0;
        sweep("pause", 960, 0, 64, 64);

        // Disabled: black output, frame counter and offsets hold
        bus.bg_en = 1'b0;
        sweep("disabled", 0, 0, 64, 16);
        for (int f = 0; f < 2; f++) do_frame();
        bus.bg_en = 1'b1;
        sweep("reenabled", 512, 704, 64, 64);
        sweep("vres_edge", 128, 760, 64, 16);

        // Blanking on known star pixels
        fa = 1'b0; fb = 1'b0; xa = 0; xb = 0;
        for (int x = 0; x < HR; x++) begin
            if (!fa && model_px(x, 767, 1'b1, 1'b1, 1'b0) != 2'd0) begin fa = 1'b1; xa = x; end
            if (!fb && model_px(x, VR, 1'b1, 1'b1, 1'b1) != 2'd0) begin fb = 1'b1; xb = x; end
        end
        if (fa) begin
            step_px(xa, 767, 1'b0, 1'b1);
            step_px(xa, 767, 1'b1, 1'b1);
        end
        if (fb) step_px(xb, VR, 1'b1, 1'b1);
        flush();
        $display("blanking star_a=%0d@767 star_b=%0d@%0d", xa, xb, VR);

        // Asynchronous reset mid-operation while a star is on the output
        if (fa) begin
            ea = model_px(xa, 767, 1'b1, 1'b1, 1'b0);
            bus.pix_x = 11'(xa);
            bus.pix_y = 11'd767;
            bus.video_active = 1'b1;
            repeat (3) @(posedge clk);
            #3;
            check_val("pre_rst_rgb", {30'd0, bus.R}, {30'd0, ea});
        end
        rst_n = 1'b0;
        #1;
        check_val("async_rst_rgb", {26'd0, bus.R, bus.G, bus.B}, 32'd0);
        off_m  = '{default: 0};
        fcnt_m = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        check_val("rel2_no_tick", 32'(tick_cnt), 32'd0);
        sweep("after_rst", 960, 0, 64, 32);
        do_frame();
        sweep("after_rst_tick", 960, 0, 64, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
